// File: rtl/fan_drive_ctrl.sv
// -----------------------------------------------------------------------------
// fan_drive_ctrl
// Battery-powered fan controller: a push button cycles the selected gear, the
// applied gear ramps one step per base tick toward the effective target, an
// optional natural-wind mode alternates between the selected gear and gear 1,
// and a battery model drains proportionally to the applied gear and recharges
// while the charger is connected.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   btn_press     in   debounced single-cycle gear-advance pulse
//   charge_en     in   charger connected
//   mode          in   0 = manual, 1 = natural wind
//   gear_target   out  user-selected gear (GW bits)
//   gear_out      out  applied, ramped gear (GW bits)
//   pwm_out       out  registered motor drive
//   battery       out  charge level (BW bits)
//   battery_empty out  battery == 0
//   charging      out  charge_en && battery < BAT_MAX
//   tick          out  one-cycle base-tick pulse
// -----------------------------------------------------------------------------
module fan_drive_ctrl #(
    parameter int NUM_GEARS  = 3,
    parameter int TICK_DIV   = 10,
    parameter int BAT_MAX    = 99,
    parameter int BAT_INIT   = BAT_MAX,
    parameter int DRAIN_UNIT = 6,
    parameter int CHG_TICKS  = 2,
    parameter int PWM_STEP   = 4,
    parameter int NAT_TICKS  = 20,
    localparam int GW = $clog2(NUM_GEARS + 1),
    localparam int BW = $clog2(BAT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          btn_press,
    input  logic          charge_en,
    input  logic          mode,
    output logic [GW-1:0] gear_target,
    output logic [GW-1:0] gear_out,
    output logic          pwm_out,
    output logic [BW-1:0] battery,
    output logic          battery_empty,
    output logic          charging,
    output logic          tick
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int PP = NUM_GEARS * PWM_STEP;
    localparam int PW = $clog2(PP + 1);
    // Holds the largest pre-subtract sum: (DRAIN_UNIT-1) + NUM_GEARS.
    localparam int AW = $clog2(DRAIN_UNIT + NUM_GEARS);
    localparam int CW = $clog2(CHG_TICKS + 1);
    localparam int NW = $clog2(NAT_TICKS + 1);

    typedef enum logic {
        PH_HIGH = 1'b0,
        PH_LOW  = 1'b1
    } nat_phase_t;

    logic [TW-1:0] tick_cnt_r, tick_cnt_nxt_s;
    logic          tick_r;
    logic [GW-1:0] gear_target_r, gear_target_nxt_s;
    logic [GW-1:0] gear_out_r, gear_out_nxt_s, eff_target_s;
    logic          mode_prev_r;
    logic [NW-1:0] nat_cnt_r, nat_cnt_nxt_s;
    nat_phase_t    nat_phase_r, nat_phase_nxt_s;
    logic [AW-1:0] acc_r, acc_nxt_s, acc_sum_s;
    logic          drain_s;
    logic [CW-1:0] chg_cnt_r, chg_cnt_nxt_s;
    logic          charge_s, charging_s, empty_s;
    logic [BW-1:0] battery_r, battery_nxt_s;
    logic [PW-1:0] pwm_cnt_r, pwm_cnt_nxt_s, duty_s;
    logic          pwm_out_r;

    // Base tick divider: wraps at TICK_DIV-1.
    always_comb begin
        if (tick_cnt_r == TW'(TICK_DIV - 1)) begin
            tick_cnt_nxt_s = TW'(1'b0);
        end else begin
            tick_cnt_nxt_s = tick_cnt_r + TW'(1'b1);
        end
    end

    // Battery status decode, follows the battery register directly.
    always_comb begin
        empty_s    = (battery_r == BW'(1'b0));
        charging_s = charge_en && (battery_r < BW'(BAT_MAX));
    end

    // Selected gear: button advances with wrap, an empty battery forces off.
    always_comb begin
        if (empty_s) begin
            gear_target_nxt_s = GW'(1'b0);
        end else if (btn_press) begin
            if (gear_target_r == GW'(NUM_GEARS)) begin
                gear_target_nxt_s = GW'(1'b0);
            end else begin
                gear_target_nxt_s = gear_target_r + GW'(1'b1);
            end
        end else begin
            gear_target_nxt_s = gear_target_r;
        end
    end

    // Natural-wind phase: restarts HIGH on any target or mode change.
    always_comb begin
        nat_cnt_nxt_s   = nat_cnt_r;
        nat_phase_nxt_s = nat_phase_r;
        if ((gear_target_nxt_s != gear_target_r) || (mode != mode_prev_r)) begin
            nat_cnt_nxt_s   = NW'(1'b0);
            nat_phase_nxt_s = PH_HIGH;
        end else if (mode && tick_r) begin
            if (nat_cnt_r == NW'(NAT_TICKS - 1)) begin
                nat_cnt_nxt_s   = NW'(1'b0);
                nat_phase_nxt_s = (nat_phase_r == PH_HIGH) ? PH_LOW : PH_HIGH;
            end else begin
                nat_cnt_nxt_s = nat_cnt_r + NW'(1'b1);
            end
        end else begin
            nat_cnt_nxt_s   = nat_cnt_r;
            nat_phase_nxt_s = nat_phase_r;
        end
    end

    // Effective target: the LOW natural phase drops to gear 1.
    always_comb begin
        if (mode && (gear_target_r > GW'(1'b1)) && (nat_phase_r == PH_LOW)) begin
            eff_target_s = GW'(1'b1);
        end else begin
            eff_target_s = gear_target_r;
        end
    end

    // Applied gear: off is immediate, everything else ramps one step per tick.
    // Uses the registered target, so a press coinciding with a tick only
    // takes effect from the following tick.
    always_comb begin
        if (empty_s || (eff_target_s == GW'(1'b0))) begin
            gear_out_nxt_s = GW'(1'b0);
        end else if (tick_r) begin
            if (eff_target_s > gear_out_r) begin
                gear_out_nxt_s = gear_out_r + GW'(1'b1);
            end else if (eff_target_s < gear_out_r) begin
                gear_out_nxt_s = gear_out_r - GW'(1'b1);
            end else begin
                gear_out_nxt_s = gear_out_r;
            end
        end else begin
            gear_out_nxt_s = gear_out_r;
        end
    end

    // Drain accumulator: integrates applied gear per tick, one unit per DRAIN_UNIT.
    always_comb begin
        acc_sum_s = acc_r + AW'(gear_out_r);
        drain_s   = 1'b0;
        acc_nxt_s = acc_r;
        if (empty_s) begin
            acc_nxt_s = AW'(1'b0);
        end else if (tick_r && (gear_out_r != GW'(1'b0))) begin
            if (acc_sum_s >= AW'(DRAIN_UNIT)) begin
                acc_nxt_s = acc_sum_s - AW'(DRAIN_UNIT);
                drain_s   = 1'b1;
            end else begin
                acc_nxt_s = acc_sum_s;
            end
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Charge counter: one unit every CHG_TICKS ticks, cleared when not charging.
    always_comb begin
        charge_s      = 1'b0;
        chg_cnt_nxt_s = chg_cnt_r;
        if (!charging_s) begin
            chg_cnt_nxt_s = CW'(1'b0);
        end else if (tick_r) begin
            if (chg_cnt_r == CW'(CHG_TICKS - 1)) begin
                chg_cnt_nxt_s = CW'(1'b0);
                charge_s      = 1'b1;
            end else begin
                chg_cnt_nxt_s = chg_cnt_r + CW'(1'b1);
            end
        end else begin
            chg_cnt_nxt_s = chg_cnt_r;
        end
    end

    // Battery level: drain and charge in the same tick cancel; saturating.
    always_comb begin
        case ({drain_s, charge_s})
            2'b10: begin
                if (battery_r != BW'(1'b0)) begin
                    battery_nxt_s = battery_r - BW'(1'b1);
                end else begin
                    battery_nxt_s = battery_r;
                end
            end
            2'b01: begin
                if (battery_r < BW'(BAT_MAX)) begin
                    battery_nxt_s = battery_r + BW'(1'b1);
                end else begin
                    battery_nxt_s = battery_r;
                end
            end
            default: battery_nxt_s = battery_r;
        endcase
    end

    // PWM period counter and duty threshold for the applied gear.
    always_comb begin
        if (pwm_cnt_r == PW'(PP - 1)) begin
            pwm_cnt_nxt_s = PW'(1'b0);
        end else begin
            pwm_cnt_nxt_s = pwm_cnt_r + PW'(1'b1);
        end
        duty_s = PW'(gear_out_r) * PW'(PWM_STEP);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r    <= TW'(1'b0);
            tick_r        <= 1'b0;
            gear_target_r <= GW'(1'b0);
            gear_out_r    <= GW'(1'b0);
            mode_prev_r   <= 1'b0;
            nat_cnt_r     <= NW'(1'b0);
            nat_phase_r   <= PH_HIGH;
            acc_r         <= AW'(1'b0);
            chg_cnt_r     <= CW'(1'b0);
            battery_r     <= BW'(BAT_INIT);
            pwm_cnt_r     <= PW'(1'b0);
            pwm_out_r     <= 1'b0;
        end else begin
            tick_cnt_r    <= tick_cnt_nxt_s;
            tick_r        <= (tick_cnt_nxt_s == TW'(TICK_DIV - 1));
            gear_target_r <= gear_target_nxt_s;
            gear_out_r    <= gear_out_nxt_s;
            mode_prev_r   <= mode;
            nat_cnt_r     <= nat_cnt_nxt_s;
            nat_phase_r   <= nat_phase_nxt_s;
            acc_r         <= acc_nxt_s;
            chg_cnt_r     <= chg_cnt_nxt_s;
            battery_r     <= battery_nxt_s;
            pwm_cnt_r     <= pwm_cnt_nxt_s;
            pwm_out_r     <= (pwm_cnt_r < duty_s);
        end
    end

    assign gear_target   = gear_target_r;
    assign gear_out      = gear_out_r;
    assign pwm_out       = pwm_out_r;
    assign battery       = battery_r;
    assign battery_empty = empty_s;
    assign charging      = charging_s;
    assign tick          = tick_r;

endmodule

// File: tb/tb_fan_drive_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fan_drive_ctrl
// Scenario-driven bench for fan_drive_ctrl with default parameters. Each task
// pushes hand-derived expectations onto a queue as it drives stimulus and pops
// them when the corresponding DUT output is due.
// -----------------------------------------------------------------------------
module tb_fan_drive_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_press;
    logic       charge_en;
    logic       mode;
    logic [1:0] gear_target;
    logic [1:0] gear_out;
    logic       pwm_out;
    logic [6:0] battery;
    logic       battery_empty;
    logic       charging;
    logic       tick;

    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    fan_drive_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_press     (btn_press),
        .charge_en     (charge_en),
        .mode          (mode),
        .gear_target   (gear_target),
        .gear_out      (gear_out),
        .pwm_out       (pwm_out),
        .battery       (battery),
        .battery_empty (battery_empty),
        .charging      (charging),
        .tick          (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until the tick pulse is visible.
    task automatic wait_tick_high();
        int n = 0;
        while (tick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_cmp++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, n);
        end
    endtask

    // Returns just after the tick edge has been processed.
    task automatic wait_tick();
        wait_tick_high();
        step();
    endtask

    task automatic press();
        btn_press = 1'b1;
        step();
        btn_press = 1'b0;
    endtask

    task automatic do_reset();
        btn_press = 1'b0;
        charge_en = 1'b0;
        mode      = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        exp_q.push_back(32'd99); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);  exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(battery) !== exp_v) begin n_fail++; $display("FAIL reset_battery got %0d required %0d", battery, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_target) !== exp_v) begin n_fail++; $display("FAIL reset_gear_target got %0d required %0d", gear_target, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_out) !== exp_v) begin n_fail++; $display("FAIL reset_gear_out got %0d required %0d", gear_out, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pwm_out) !== exp_v) begin n_fail++; $display("FAIL reset_pwm_out got %0d required %0d", pwm_out, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(tick) !== exp_v) begin n_fail++; $display("FAIL reset_tick got %0d required %0d", tick, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(battery_empty) !== exp_v) begin n_fail++; $display("FAIL reset_empty got %0d required %0d", battery_empty, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(charging) !== exp_v) begin n_fail++; $display("FAIL reset_charging got %0d required %0d", charging, exp_v); end

        // First tick lands when the counter reaches 9, then every 10 cycles.
        exp_q.push_back(32'd9); exp_q.push_back(32'd0); exp_q.push_back(32'd10);
        n = 0;
        while (tick !== 1'b1 && n < 40) begin step(); n++; end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(n) !== exp_v) begin n_fail++; $display("FAIL tick_first got %0d cycles required %0d", n, exp_v); end
        step();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(tick) !== exp_v) begin n_fail++; $display("FAIL tick_width got %0d required %0d", tick, exp_v); end
        n = 1;
        while (tick !== 1'b1 && n < 40) begin step(); n++; end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(n) !== exp_v) begin n_fail++; $display("FAIL tick_period got %0d cycles required %0d", n, exp_v); end

        // Charger on a full battery does not report charging.
        charge_en = 1'b1;
        exp_q.push_back(32'd0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(charging) !== exp_v) begin n_fail++; $display("FAIL charging_full got %0d required %0d", charging, exp_v); end
        charge_en = 1'b0;
    endtask

    task automatic test_ramp();
        int highs;
        do_reset();
        wait_tick();
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
        press(); press(); press();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_target) !== exp_v) begin n_fail++; $display("FAIL ramp_target got %0d required %0d", gear_target, exp_v); end
        for (int k = 1; k <= 3; k++) begin
            wait_tick();
            exp_v = exp_q.pop_front(); n_cmp++;
            if (32'(gear_out) !== exp_v) begin n_fail++; $display("FAIL ramp_gear_out tick=%0d got %0d required %0d", k, gear_out, exp_v); end
        end
        step();
        exp_q.push_back(32'd12);
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            if (pwm_out === 1'b1) highs++;
            step();
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(highs) !== exp_v) begin n_fail++; $display("FAIL pwm_gear3 got %0d high cycles required %0d", highs, exp_v); end
    endtask

    task automatic test_press_tick();
        do_reset();
        wait_tick_high();
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        press();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_target) !== exp_v) begin n_fail++; $display("FAIL press_tick_target got %0d required %0d", gear_target, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_out) !== exp_v) begin n_fail++; $display("FAIL press_tick_hold got %0d required %0d", gear_out, exp_v); end
        wait_tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_out) !== exp_v) begin n_fail++; $display("FAIL press_tick_next got %0d required %0d", gear_out, exp_v); end
    endtask

    task automatic test_drain_charge();
        int e;
        do_reset();
        wait_tick();
        press(); press(); press();
        wait_tick(); wait_tick(); wait_tick();
        // Gear 3 with an accumulator of 3: one unit every 2 ticks.
        for (int k = 1; k <= 19; k++) exp_q.push_back(32'(99 - (k + 1) / 2));
        for (int k = 1; k <= 19; k++) begin
            wait_tick();
            exp_v = exp_q.pop_front(); n_cmp++;
            if (32'(battery) !== exp_v) begin n_fail++; $display("FAIL drain_g3 tick=%0d got %0d required %0d", k, battery, exp_v); end
        end
        // Drain and charge coincide every second tick: level holds.
        charge_en = 1'b1;
        for (int k = 0; k < 10; k++) exp_q.push_back(32'd89);
        for (int k = 0; k < 10; k++) begin
            wait_tick();
            exp_v = exp_q.pop_front(); n_cmp++;
            if (32'(battery) !== exp_v) begin n_fail++; $display("FAIL drain_charge_hold tick=%0d got %0d required %0d", k, battery, exp_v); end
        end
        // Button wrap turns the fan off without a ramp.
        charge_en = 1'b0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd89);
        press();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_target) !== exp_v) begin n_fail++; $display("FAIL wrap_target got %0d required %0d", gear_target, exp_v); end
        step();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_out) !== exp_v) begin n_fail++; $display("FAIL wrap_gear_out got %0d required %0d", gear_out, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(battery) !== exp_v) begin n_fail++; $display("FAIL wrap_battery got %0d required %0d", battery, exp_v); end
        // Charge at gear 0: +1 every 2 ticks, saturating at 99.
        charge_en = 1'b1;
        for (int m = 1; m <= 24; m++) begin
            e = 89 + m / 2;
            if (e > 99) e = 99;
            exp_q.push_back(32'(e));
        end
        for (int m = 1; m <= 24; m++) begin
            wait_tick();
            exp_v = exp_q.pop_front(); n_cmp++;
            if (32'(battery) !== exp_v) begin n_fail++; $display("FAIL charge_g0 tick=%0d got %0d required %0d", m, battery, exp_v); end
        end
        exp_q.push_back(32'd0);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(charging) !== exp_v) begin n_fail++; $display("FAIL charging_at_max got %0d required %0d", charging, exp_v); end
        charge_en = 1'b0;
    endtask

    task automatic test_drain_gear1();
        do_reset();
        wait_tick();
        press();
        wait_tick();
        for (int j = 1; j <= 6; j++) exp_q.push_back((j < 6) ? 32'd99 : 32'd98);
        for (int j = 1; j <= 6; j++) begin
            wait_tick();
            exp_v = exp_q.pop_front(); n_cmp++;
            if (32'(battery) !== exp_v) begin n_fail++; $display("FAIL drain_g1 tick=%0d got %0d required %0d", j, battery, exp_v); end
        end
    endtask

    task automatic test_empty();
        int k;
        int highs;
        do_reset();
        wait_tick();
        press(); press(); press();
        wait_tick(); wait_tick(); wait_tick();
        exp_q.push_back(32'd197); exp_q.push_back(32'd1);
        k = 0;
        do begin
            wait_tick();
            k++;
        end while (battery !== 7'd0 && k < 250);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(k) !== exp_v) begin n_fail++; $display("FAIL empty_ticks got %0d required %0d", k, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(battery_empty) !== exp_v) begin n_fail++; $display("FAIL empty_flag got %0d required %0d", battery_empty, exp_v); end
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        step();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_target) !== exp_v) begin n_fail++; $display("FAIL empty_target got %0d required %0d", gear_target, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_out) !== exp_v) begin n_fail++; $display("FAIL empty_gear_out got %0d required %0d", gear_out, exp_v); end
        step();
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            if (pwm_out !== 1'b0) highs++;
            step();
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(highs) !== exp_v) begin n_fail++; $display("FAIL empty_pwm got %0d high cycles required %0d", highs, exp_v); end
        // Press ignored, battery saturates at 0.
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        press();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_target) !== exp_v) begin n_fail++; $display("FAIL empty_press_ignored got %0d required %0d", gear_target, exp_v); end
        wait_tick(); wait_tick(); wait_tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(battery) !== exp_v) begin n_fail++; $display("FAIL empty_saturate got %0d required %0d", battery, exp_v); end
        // Recharge one unit: empty clears, gears stay off.
        charge_en = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        wait_tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(battery) !== exp_v) begin n_fail++; $display("FAIL recharge_first got %0d required %0d", battery, exp_v); end
        wait_tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(battery) !== exp_v) begin n_fail++; $display("FAIL recharge_second got %0d required %0d", battery, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(battery_empty) !== exp_v) begin n_fail++; $display("FAIL recharge_empty got %0d required %0d", battery_empty, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_target) !== exp_v) begin n_fail++; $display("FAIL recharge_target got %0d required %0d", gear_target, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_out) !== exp_v) begin n_fail++; $display("FAIL recharge_gear_out got %0d required %0d", gear_out, exp_v); end
        charge_en = 1'b0;
    endtask

    task automatic test_natural();
        int highs;
        do_reset();
        wait_tick();
        press(); press();
        wait_tick(); wait_tick();
        step();
        exp_q.push_back(32'd8);
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            if (pwm_out === 1'b1) highs++;
            step();
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(highs) !== exp_v) begin n_fail++; $display("FAIL pwm_gear2 got %0d high cycles required %0d", highs, exp_v); end
        wait_tick();
        mode = 1'b1;
        for (int k = 1; k <= 45; k++) exp_q.push_back((k <= 20 || k > 40) ? 32'd2 : 32'd1);
        for (int k = 1; k <= 45; k++) begin
            wait_tick();
            exp_v = exp_q.pop_front(); n_cmp++;
            if (32'(gear_out) !== exp_v) begin n_fail++; $display("FAIL natural_gear_out tick=%0d got %0d required %0d", k, gear_out, exp_v); end
        end
        mode = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        wait_tick();
        press(); press(); press();
        wait_tick(); wait_tick();
        exp_q.push_back(32'd2);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_out) !== exp_v) begin n_fail++; $display("FAIL async_pre_gear_out got %0d required %0d", gear_out, exp_v); end
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd99); exp_q.push_back(32'd0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_out) !== exp_v) begin n_fail++; $display("FAIL async_gear_out got %0d required %0d", gear_out, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(gear_target) !== exp_v) begin n_fail++; $display("FAIL async_target got %0d required %0d", gear_target, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(pwm_out) !== exp_v) begin n_fail++; $display("FAIL async_pwm got %0d required %0d", pwm_out, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(battery) !== exp_v) begin n_fail++; $display("FAIL async_battery got %0d required %0d", battery, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(tick) !== exp_v) begin n_fail++; $display("FAIL async_tick got %0d required %0d", tick, exp_v); end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        btn_press = 1'b0;
        charge_en = 1'b0;
        mode      = 1'b0;
        test_reset();
        test_ramp();
        test_press_tick();
        test_drain_charge();
        test_drain_gear1();
        test_empty();
        test_natural();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
